led_sopc_onchip_ram_dp: RTL
===========================

// Module: led_sopc_onchip_ram_dp
// PURPOSE
//  Parametrised dual-slave (s1/s2) Avalon-MM on-chip RAM for the SOPC system: true dual-port storage,
//  per-port byte enables, pipelined reads with readdatavalid, and a post-reset clear engine.
//  Successor to the single-port on-chip memory. Sits on the system interconnect:
//  s1 serves the CPU instruction/data master, s2 a DMA or second master.
// PARAMETERS
//  DATA_W          32      data width per port, multiple of 8
//  DEPTH           10240   words; need not be a power of 2
//  ADDR_W          14      word address width, >= clog2(DEPTH)
//  READ_LATENCY    1       1 or 2; accepted read -> readdatavalid, in cycles
//  CLEAR_ON_RESET  1       1: zero every word after reset; 0: no clear, array holds prior contents
// PORTS
//  clk               in   1         single clock for both ports
//  reset             in   1         synchronous, active-high
//  sN_address        in   ADDR_W    word address (N = 1,2 throughout)
//  sN_chipselect     in   1         port select
//  sN_read           in   1         read request
//  sN_write          in   1         write request
//  sN_byteenable     in   DATA_W/8  byte lane enables for writes
//  sN_writedata      in   DATA_W    write data
//  sN_readdata       out  DATA_W    read data; valid only when sN_readdatavalid=1
//  sN_readdatavalid  out  1         one-cycle pulse per accepted read
//  sN_waitrequest    out  1         high while clearing; otherwise 0
//  init_done         out  1         high once clear engine finished (or immediately if CLEAR_ON_RESET=0)
// BEHAVIOUR
//  Reset: readdata=0, readdatavalid=0, pipeline flushed, init_done=0, waitrequest=1 if CLEAR_ON_RESET else 0.
//  FSM: CLEAR -> RUN. CLEAR writes 0 to address clr_ptr (0..DEPTH-1), one word/cycle, all lanes.
//   After DEPTH cycles -> RUN; init_done=1, waitrequest=0 on the following cycle.
//   reset during CLEAR restarts at address 0. CLEAR_ON_RESET=0: reset goes straight to RUN.
//  Accept: op accepted when chipselect & ~waitrequest. Requests during CLEAR are held off.
//   Masters hold requests while waitrequest=1.
//  Write: array lanes with byteenable=1 updated at the accepting edge; other lanes untouched.
//  Read: data sampled at the accepting edge; readdata/readdatavalid appear READ_LATENCY cycles later.
//   Fully pipelined: one read per cycle per port, no bubbles.
//  read & write both high on a port: write performed, no read issued, no readdatavalid.
//  Address >= DEPTH: write ignored; read completes normally with readdata=0.
//  Same-address collisions, same cycle:
//   both ports write: s1 data wins on lanes enabled by both; other lanes follow their own enables.
//   one port reads, the other writes: reader gets OLD data (read-before-write).
//   both ports read: both get same data.
//  Same port, read issued cycle after write to same address: returns new data.
//  readdata is 0 whenever readdatavalid=0.
// CONFIGURATION
//  Macro ONCHIP_RAM_PARITY_EN:
//   defined: one even-parity bit stored per byte lane, written with the data.
//    On each readdatavalid, recomputed parity is checked against stored parity.
//    Mismatch pulses sN_parity_err (out, 1) for one cycle, aligned with readdatavalid.
//    Clear engine writes parity 0.
//   undefined: no parity storage; sN_parity_err ports absent.
// STRUCTURE
//  Package led_sopc_onchip_pkg: RD_LAT_MAX=2; state enum {ST_CLEAR, ST_RUN}; function byte_parity().
//  Sub-module onchip_ram_dp_core: inferred true-dual-port array, width DATA_W(+DATA_W/8 parity),
//   per-port byte-enable writes, read-before-write.
//  Top: clear FSM, address range check, collision priority, latency pipeline, parity check.
// TESTING
//  Clear: reset 1 cycle, CLEAR_ON_RESET=1, DEPTH=16.
//   -> waitrequest=1 exactly 16 cycles, then init_done=1; read every address -> 0.
//  Byte lanes: s1 write 0x11223344 @5, be=4'b1111; then be=4'b0101 data 0xAABBCCDD.
//   -> s2 read @5 returns 0x11BB33DD after READ_LATENCY.
//  Collision: same cycle, s1 writes 0xA5A5A5A5 @3 and s2 writes 0x5A5A5A5A @3, both be=4'hF.
//   -> read @3 = 0xA5A5A5A5.
//   Then s1 writes 0x1 @3 while s2 reads @3 -> s2 gets 0xA5A5A5A5.
//  Pipelining: READ_LATENCY=2; s1 reads @0..7 on consecutive cycles.
//   -> 8 consecutive readdatavalid pulses starting 2 cycles after first accept, data in order.
//  Range/reset: DEPTH=10240; write @10240 then read @10240 -> readdata=0, valid pulse present.
//   Assert reset mid-CLEAR at clr_ptr=7 -> clear restarts at 0, full DEPTH cycles again.
//  Parity (macro on): force-flip one stored bit @9, read @9 -> s1_parity_err=1 with readdatavalid.

Source files
------------

// File: rtl/led_sopc_onchip_pkg.sv
// Shared types and helpers for the dual-port on-chip RAM.
package led_sopc_onchip_pkg;

    localparam int unsigned RD_LAT_MAX = 2;

    typedef enum logic {StClear, StRun} state_e;

    // Even parity: the stored bit makes the 9-bit lane have an even number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/onchip_ram_dp_core.sv
// True dual-port lane-writable array with registered, read-before-write outputs.
module onchip_ram_dp_core #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned DEPTH  = 10240,
    parameter int unsigned ADDR_W = 14
) (
    input  logic                     clk_i,
    input  logic                     a_we_i,
    input  logic [ADDR_W-1:0]        a_addr_i,
    input  logic [LANES-1:0]         a_be_i,
    input  logic [LANES*LANE_W-1:0]  a_wdata_i,
    output logic [LANES*LANE_W-1:0]  a_rdata_o,
    input  logic                     b_we_i,
    input  logic [ADDR_W-1:0]        b_addr_i,
    input  logic [LANES-1:0]         b_be_i,
    input  logic [LANES*LANE_W-1:0]  b_wdata_i,
    output logic [LANES*LANE_W-1:0]  b_rdata_o
);
    localparam int unsigned MEM_W = LANES * LANE_W;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [MEM_W-1:0] mem [DEPTH];
    logic [MEM_W-1:0] a_rdata_q, b_rdata_q;

    // Port a is applied last so it wins on lanes both ports enable.
    always_ff @(posedge clk_i) begin
        a_rdata_q <= mem[a_addr_i[IDX_W-1:0]];
        b_rdata_q <= mem[b_addr_i[IDX_W-1:0]];
        for (int l = 0; l < LANES; l++) begin
            if (b_we_i && b_be_i[l]) begin
                mem[b_addr_i[IDX_W-1:0]][l*LANE_W +: LANE_W] <= b_wdata_i[l*LANE_W +: LANE_W];
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (a_we_i && a_be_i[l]) begin
                mem[a_addr_i[IDX_W-1:0]][l*LANE_W +: LANE_W] <= a_wdata_i[l*LANE_W +: LANE_W];
            end
        end
    end

    assign a_rdata_o = a_rdata_q;
    assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/led_sopc_onchip_ram_dp.sv
// Dual-slave Avalon-MM on-chip RAM: clear engine, range check, pipelined reads.
// Define ONCHIP_RAM_PARITY_EN to store and check one even-parity bit per byte lane.
module led_sopc_onchip_ram_dp
    import led_sopc_onchip_pkg::*;
#(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned DEPTH          = 10240,
    parameter int unsigned ADDR_W         = 14,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [ADDR_W-1:0]   s1_address_i,
    input  logic                s1_chipselect_i,
    input  logic                s1_read_i,
    input  logic                s1_write_i,
    input  logic [DATA_W/8-1:0] s1_byteenable_i,
    input  logic [DATA_W-1:0]   s1_writedata_i,
    output logic [DATA_W-1:0]   s1_readdata_o,
    output logic                s1_readdatavalid_o,
    output logic                s1_waitrequest_o,
    input  logic [ADDR_W-1:0]   s2_address_i,
    input  logic                s2_chipselect_i,
    input  logic                s2_read_i,
    input  logic                s2_write_i,
    input  logic [DATA_W/8-1:0] s2_byteenable_i,
    input  logic [DATA_W-1:0]   s2_writedata_i,
    output logic [DATA_W-1:0]   s2_readdata_o,
    output logic                s2_readdatavalid_o,
    output logic                s2_waitrequest_o,
`ifdef ONCHIP_RAM_PARITY_EN
    output logic                s1_parity_err_o,
    output logic                s2_parity_err_o,
`endif
    output logic                init_done_o
);
    localparam int unsigned LANES = DATA_W / 8;
`ifdef ONCHIP_RAM_PARITY_EN
    localparam int unsigned LANE_W = 9;
`else
    localparam int unsigned LANE_W = 8;
`endif
    localparam int unsigned MEM_W = LANES * LANE_W;

    state_e            state_q;
    logic [ADDR_W-1:0] clr_ptr_q;
    logic              waitreq_q, init_done_q, clearing;

    logic [1:0]                   cs, rd, wr, accept, in_range, we, rd_issue;
    logic [1:0][ADDR_W-1:0]       addr;
    logic [1:0][LANES-1:0]        be;
    logic [1:0][DATA_W-1:0]       wdata, rdata;
    logic [1:0][MEM_W-1:0]        wdata_ext;
    logic [MEM_W-1:0]             core_rdata [2];
    logic [MEM_W-1:0]             rout [2];
    logic                         rvalid [2];
    logic                         a_we;
    logic [ADDR_W-1:0]            a_addr;
    logic [LANES-1:0]             a_be;
    logic [MEM_W-1:0]             a_wdata;

    assign cs    = {s2_chipselect_i, s1_chipselect_i};
    assign rd    = {s2_read_i, s1_read_i};
    assign wr    = {s2_write_i, s1_write_i};
    assign addr  = {s2_address_i, s1_address_i};
    assign be    = {s2_byteenable_i, s1_byteenable_i};
    assign wdata = {s2_writedata_i, s1_writedata_i};

    assign clearing = (state_q == StClear) && !reset_i;

    always_comb begin
        accept    = '0;
        in_range  = '0;
        we        = '0;
        rd_issue  = '0;
        wdata_ext = '0;
        for (int p = 0; p < 2; p++) begin
            accept[p]   = cs[p] & ~waitreq_q & ~reset_i;
            in_range[p] = 32'(addr[p]) < DEPTH;
            we[p]       = accept[p] & wr[p] & in_range[p];
            rd_issue[p] = accept[p] & rd[p] & ~wr[p];
            for (int l = 0; l < LANES; l++) begin
                wdata_ext[p][l*LANE_W +: 8] = wdata[p][l*8 +: 8];
`ifdef ONCHIP_RAM_PARITY_EN
                wdata_ext[p][l*LANE_W + 8] = byte_parity(wdata[p][l*8 +: 8]);
`endif
            end
        end
    end

    // The clear engine borrows port a; no s1 access can be accepted while it runs.
    always_comb begin
        a_we    = we[0];
        a_addr  = addr[0];
        a_be    = be[0];
        a_wdata = wdata_ext[0];
        if (clearing) begin
            a_we    = 1'b1;
            a_addr  = clr_ptr_q;
            a_be    = '1;
            a_wdata = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
            clr_ptr_q   <= '0;
            init_done_q <= 1'b0;
            waitreq_q   <= (CLEAR_ON_RESET != 0);
        end else begin
            unique case (state_q)
                StClear: begin
                    if (32'(clr_ptr_q) == DEPTH - 1) begin
                        state_q     <= StRun;
                        waitreq_q   <= 1'b0;
                        init_done_q <= 1'b1;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 1'b1;
                    end
                end
                StRun: begin
                    waitreq_q   <= 1'b0;
                    init_done_q <= 1'b1;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    onchip_ram_dp_core #(
        .LANES  (LANES),
        .LANE_W (LANE_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_core (
        .clk_i     (clk_i),
        .a_we_i    (a_we),
        .a_addr_i  (a_addr),
        .a_be_i    (a_be),
        .a_wdata_i (a_wdata),
        .a_rdata_o (core_rdata[0]),
        .b_we_i    (we[1]),
        .b_addr_i  (addr[1]),
        .b_be_i    (be[1]),
        .b_wdata_i (wdata_ext[1]),
        .b_rdata_o (core_rdata[1])
    );

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic             v1_q, oor1_q;
        logic [MEM_W-1:0] raw1;

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                v1_q   <= 1'b0;
                oor1_q <= 1'b0;
            end else begin
                v1_q   <= rd_issue[p];
                oor1_q <= ~in_range[p];
            end
        end

        // Out-of-range reads and idle cycles present zero.
        assign raw1 = (v1_q && !oor1_q) ? core_rdata[p] : '0;

        if (READ_LATENCY >= RD_LAT_MAX) begin : g_lat2
            logic             v2_q;
            logic [MEM_W-1:0] raw2_q;
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    v2_q   <= 1'b0;
                    raw2_q <= '0;
                end else begin
                    v2_q   <= v1_q;
                    raw2_q <= raw1;
                end
            end
            assign rvalid[p] = v2_q;
            assign rout[p]   = raw2_q;
        end else begin : g_lat1
            assign rvalid[p] = v1_q;
            assign rout[p]   = raw1;
        end
    end

    always_comb begin
        rdata = '0;
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < LANES; l++) begin
                rdata[p][l*8 +: 8] = rout[p][l*LANE_W +: 8];
            end
        end
    end

`ifdef ONCHIP_RAM_PARITY_EN
    logic [1:0] perr;
    always_comb begin
        perr = '0;
        for (int p = 0; p < 2; p++) begin
            for (int l = 0; l < LANES; l++) begin
                if (byte_parity(rout[p][l*LANE_W +: 8]) != rout[p][l*LANE_W + 8]) begin
                    perr[p] = rvalid[p];
                end
            end
        end
    end
    assign s1_parity_err_o = perr[0];
    assign s2_parity_err_o = perr[1];
`endif

    assign s1_readdata_o      = rdata[0];
    assign s2_readdata_o      = rdata[1];
    assign s1_readdatavalid_o = rvalid[0];
    assign s2_readdatavalid_o = rvalid[1];
    assign s1_waitrequest_o   = waitreq_q;
    assign s2_waitrequest_o   = waitreq_q;
    assign init_done_o        = init_done_q;

endmodule
